// File: rtl/fetch_queue_pkg.sv
// Shared RV32I fetch definitions: datapath width, pc step, canonical nop and
// the {pc, instr} entry carried from fetch to decode.
package fetch_queue_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned PC_STEP = 4;

    // addi x0,x0,0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle.
//   In_Valid/In_Pc/In_Instr/In_Ready : push side, from the PC / instruction memory
//   Out_Valid/Out_Pc/Out_Pc4/Out_Instr/Out_Ready : pop side, to decode
// slave  : the queue's view
// master : the surrounding pipeline's view (fetch drives In_*, decode drives Out_Ready)
interface fetch_queue_if;
    import fetch_queue_pkg::*;

    logic            In_Valid;
    logic [XLEN-1:0] In_Pc;
    logic [XLEN-1:0] In_Instr;
    logic            In_Ready;

    logic            Out_Valid;
    logic [XLEN-1:0] Out_Pc;
    logic [XLEN-1:0] Out_Pc4;
    logic [XLEN-1:0] Out_Instr;
    logic            Out_Ready;

    modport slave (
        input  In_Valid, In_Pc, In_Instr, Out_Ready,
        output In_Ready, Out_Valid, Out_Pc, Out_Pc4, Out_Instr
    );

    modport master (
        output In_Valid, In_Pc, In_Instr, Out_Ready,
        input  In_Ready, Out_Valid, Out_Pc, Out_Pc4, Out_Instr
    );

endinterface

// File: rtl/fetch_queue_ram.sv
// DEPTH x fetch_entry_t register array: one synchronous write port, one
// asynchronous read port. Not reset; the owner masks stale contents.
//   clk     : write clock
//   wr_en   : write enable
//   wr_addr : write index
//   wr_data : entry to store
//   rd_addr : read index
//   rd_data : entry at rd_addr (combinational)
module fetch_queue_ram
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  fetch_entry_t      wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output fetch_entry_t      rd_data
);

    fetch_entry_t mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// In-order instruction fetch queue between the PC register and decode.
// Buffers up to DEPTH {pc, instr} pairs, presents the oldest to decode,
// back-pressures the PC through In_Ready and drops everything on Flush.
//   Clk   : clock, rising edge
//   Reset : asynchronous, active-high
//   Flush : redirect; clears the queue and ignores same-cycle push/pop
//   bus   : fetch_queue_if.slave handshake (In_* push side, Out_* pop side)
//   Count : number of valid entries
module fetch_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = fetch_queue_pkg::NOP_INSTR
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Flush,
    fetch_queue_if.slave             bus,
    output logic [$clog2(DEPTH):0]   Count
);
    import fetch_queue_pkg::*;

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    // MSB of each pointer is the wrap bit
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic         empty;
    logic         full;
    logic         push;
    logic         pop;
    fetch_entry_t wr_entry;
    fetch_entry_t rd_entry;

    // Queue status from the pointer pair only
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                   (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);

    // In_Ready is state-only, so a pop while full cannot admit a push in the same cycle
    assign push = bus.In_Valid && !full && !Flush;
    assign pop  = !empty && bus.Out_Ready && !Flush;

    // Pointer update; Flush outranks push and pop
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (Flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    assign wr_entry.pc    = bus.In_Pc;
    assign wr_entry.instr = bus.In_Instr;

    // Entry storage
    fetch_queue_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (IDX_W)
    ) u_ram (
        .clk     (Clk),
        .wr_en   (push),
        .wr_addr (wr_ptr[IDX_W-1:0]),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr[IDX_W-1:0]),
        .rd_data (rd_entry)
    );

    // Handshake outputs; unwritten storage is hidden while empty
    assign bus.In_Ready  = !full;
    assign bus.Out_Valid = !empty;
    assign bus.Out_Pc    = empty ? '0 : rd_entry.pc;
    assign bus.Out_Instr = empty ? NOP_INSTR : rd_entry.instr;
    assign bus.Out_Pc4   = bus.Out_Pc + XLEN'(PC_STEP);

    // Modular difference gives occupancy across wrap
    assign Count = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH = 4).
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    logic       Clk;
    logic       Reset;
    logic       Flush;
    logic [2:0] Count;

    int vectors;
    int miscompares;

    fetch_queue_if fq ();

    fetch_queue #(
        .DEPTH     (4),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Flush (Flush),
        .bus   (fq),
        .Count (Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance one edge and settle away from it
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_idle();
        Flush        = 1'b0;
        fq.In_Valid  = 1'b0;
        fq.In_Pc     = 32'h0;
        fq.In_Instr  = 32'h0;
        fq.Out_Ready = 1'b0;
    endtask

    task automatic push_one(input logic [31:0] pc, input logic [31:0] instr);
        fq.In_Valid = 1'b1;
        fq.In_Pc    = pc;
        fq.In_Instr = instr;
        tick();
        fq.In_Valid = 1'b0;
    endtask

    task automatic do_flush();
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        drive_idle();
        #12;
        vectors++; if (fq.Out_Valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %0b exp 0", fq.Out_Valid); end
        vectors++; if (fq.Out_Pc !== 32'h0) begin miscompares++; $display("FAIL reset_out_pc got %h exp 00000000", fq.Out_Pc); end
        vectors++; if (fq.Out_Pc4 !== 32'h4) begin miscompares++; $display("FAIL reset_out_pc4 got %h exp 00000004", fq.Out_Pc4); end
        vectors++; if (fq.Out_Instr !== 32'h0000_0013) begin miscompares++; $display("FAIL reset_out_instr got %h exp 00000013", fq.Out_Instr); end
        vectors++; if (Count !== 3'd0) begin miscompares++; $display("FAIL reset_count got %0d exp 0", Count); end
        vectors++; if (fq.In_Ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %0b exp 1", fq.In_Ready); end
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_single_push();
        push_one(32'h0, 32'h0050_0093);
        vectors++; if (fq.Out_Valid !== 1'b1) begin miscompares++; $display("FAIL single_out_valid got %0b exp 1", fq.Out_Valid); end
        vectors++; if (fq.Out_Pc !== 32'h0) begin miscompares++; $display("FAIL single_out_pc got %h exp 00000000", fq.Out_Pc); end
        vectors++; if (fq.Out_Pc4 !== 32'h4) begin miscompares++; $display("FAIL single_out_pc4 got %h exp 00000004", fq.Out_Pc4); end
        vectors++; if (fq.Out_Instr !== 32'h0050_0093) begin miscompares++; $display("FAIL single_out_instr got %h exp 00500093", fq.Out_Instr); end
        vectors++; if (Count !== 3'd1) begin miscompares++; $display("FAIL single_count got %0d exp 1", Count); end
        // Hold without Out_Ready: entry must stay
        tick();
        vectors++; if (Count !== 3'd1) begin miscompares++; $display("FAIL single_hold_count got %0d exp 1", Count); end
        fq.Out_Ready = 1'b1;
        tick();
        fq.Out_Ready = 1'b0;
        vectors++; if (fq.Out_Valid !== 1'b0) begin miscompares++; $display("FAIL single_pop_valid got %0b exp 0", fq.Out_Valid); end
        vectors++; if (Count !== 3'd0) begin miscompares++; $display("FAIL single_pop_count got %0d exp 0", Count); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            push_one(32'(4 * i), 32'hA000_0000 + 32'(i));
        end
        vectors++; if (Count !== 3'd4) begin miscompares++; $display("FAIL fill_count got %0d exp 4", Count); end
        vectors++; if (fq.In_Ready !== 1'b0) begin miscompares++; $display("FAIL fill_in_ready got %0b exp 0", fq.In_Ready); end
        // Fifth push while full is a no-op
        push_one(32'h10, 32'hA000_0004);
        vectors++; if (Count !== 3'd4) begin miscompares++; $display("FAIL fill_fifth_count got %0d exp 4", Count); end
        vectors++; if (fq.Out_Pc !== 32'h0) begin miscompares++; $display("FAIL fill_fifth_head got %h exp 00000000", fq.Out_Pc); end
        // Pop while full with In_Valid high: push stays blocked this cycle
        fq.Out_Ready = 1'b1;
        fq.In_Valid  = 1'b1;
        fq.In_Pc     = 32'h10;
        fq.In_Instr  = 32'hA000_0004;
        tick();
        fq.Out_Ready = 1'b0;
        fq.In_Valid  = 1'b0;
        vectors++; if (Count !== 3'd3) begin miscompares++; $display("FAIL fill_pop_count got %0d exp 3", Count); end
        vectors++; if (fq.Out_Pc !== 32'h4) begin miscompares++; $display("FAIL fill_pop_head got %h exp 00000004", fq.Out_Pc); end
        vectors++; if (fq.Out_Instr !== 32'hA000_0001) begin miscompares++; $display("FAIL fill_pop_instr got %h exp a0000001", fq.Out_Instr); end
        vectors++; if (fq.In_Ready !== 1'b1) begin miscompares++; $display("FAIL fill_pop_in_ready got %0b exp 1", fq.In_Ready); end
        do_flush();
    endtask

    task automatic test_back_to_back();
        fq.Out_Ready = 1'b1;
        fq.In_Valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            fq.In_Pc    = 32'(4 * i);
            fq.In_Instr = 32'hB000_0000 + 32'(i);
            tick();
            vectors++; if (fq.Out_Pc !== 32'(4 * i)) begin miscompares++; $display("FAIL stream_pc[%0d] got %h exp %h", i, fq.Out_Pc, 32'(4 * i)); end
            vectors++; if (fq.Out_Instr !== 32'hB000_0000 + 32'(i)) begin miscompares++; $display("FAIL stream_instr[%0d] got %h exp %h", i, fq.Out_Instr, 32'hB000_0000 + 32'(i)); end
            vectors++; if (Count !== 3'd1) begin miscompares++; $display("FAIL stream_count[%0d] got %0d exp 1", i, Count); end
        end
        fq.In_Valid = 1'b0;
        tick();
        fq.Out_Ready = 1'b0;
        vectors++; if (Count !== 3'd0) begin miscompares++; $display("FAIL stream_drain_count got %0d exp 0", Count); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            push_one(32'(4 * i), 32'hC000_0000 + 32'(i));
        end
        vectors++; if (Count !== 3'd3) begin miscompares++; $display("FAIL flush_pre_count got %0d exp 3", Count); end
        Flush        = 1'b1;
        fq.In_Valid  = 1'b1;
        fq.In_Pc     = 32'h10;
        fq.In_Instr  = 32'hC000_0010;
        fq.Out_Ready = 1'b1;
        tick();
        Flush        = 1'b0;
        fq.In_Valid  = 1'b0;
        fq.Out_Ready = 1'b0;
        vectors++; if (Count !== 3'd0) begin miscompares++; $display("FAIL flush_count got %0d exp 0", Count); end
        vectors++; if (fq.Out_Valid !== 1'b0) begin miscompares++; $display("FAIL flush_out_valid got %0b exp 0", fq.Out_Valid); end
        vectors++; if (fq.Out_Instr !== 32'h0000_0013) begin miscompares++; $display("FAIL flush_out_instr got %h exp 00000013", fq.Out_Instr); end
        vectors++; if (fq.Out_Pc !== 32'h0) begin miscompares++; $display("FAIL flush_out_pc got %h exp 00000000", fq.Out_Pc); end
        vectors++; if (fq.In_Ready !== 1'b1) begin miscompares++; $display("FAIL flush_in_ready got %0b exp 1", fq.In_Ready); end
        tick();
        vectors++; if (fq.Out_Valid !== 1'b0) begin miscompares++; $display("FAIL flush_late_valid got %0b exp 0", fq.Out_Valid); end
    endtask

    task automatic test_async_reset();
        push_one(32'h20, 32'hD000_0020);
        push_one(32'h24, 32'hD000_0024);
        vectors++; if (Count !== 3'd2) begin miscompares++; $display("FAIL areset_pre_count got %0d exp 2", Count); end
        #2;
        Reset = 1'b1;
        #1;
        vectors++; if (fq.Out_Valid !== 1'b0) begin miscompares++; $display("FAIL areset_out_valid got %0b exp 0", fq.Out_Valid); end
        vectors++; if (fq.Out_Pc !== 32'h0) begin miscompares++; $display("FAIL areset_out_pc got %h exp 00000000", fq.Out_Pc); end
        vectors++; if (Count !== 3'd0) begin miscompares++; $display("FAIL areset_count got %0d exp 0", Count); end
        vectors++; if (fq.In_Ready !== 1'b1) begin miscompares++; $display("FAIL areset_in_ready got %0b exp 1", fq.In_Ready); end
        tick();
        Reset = 1'b0;
        tick();
        push_one(32'h0, 32'hD000_0000);
        vectors++; if (fq.Out_Pc !== 32'h0) begin miscompares++; $display("FAIL areset_after_pc got %h exp 00000000", fq.Out_Pc); end
        vectors++; if (fq.Out_Instr !== 32'hD000_0000) begin miscompares++; $display("FAIL areset_after_instr got %h exp d0000000", fq.Out_Instr); end
        vectors++; if (Count !== 3'd1) begin miscompares++; $display("FAIL areset_after_count got %0d exp 1", Count); end
        do_flush();
    endtask

    task automatic test_pc4_wrap();
        push_one(32'hFFFF_FFFC, 32'h0000_006F);
        vectors++; if (fq.Out_Pc !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL pc4_out_pc got %h exp fffffffc", fq.Out_Pc); end
        vectors++; if (fq.Out_Pc4 !== 32'h0) begin miscompares++; $display("FAIL pc4_carry got %h exp 00000000", fq.Out_Pc4); end
        do_flush();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single_push();
        test_fill();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_pc4_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
